// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// IRWrite/PCWrite in FETCH are the only outputs qualified by mem_ready.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUctr,
    output logic [3:0] state,
    output logic       trap
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRgExe  = 4'd6,
        StRgWb   = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StIExe   = 4'd10,
        StIWb    = 4'd11,
        StTrap   = 4'd12
    } state_e;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpAddi  = 6'b001000;

    state_e     state_q, state_d;
    logic [5:0] op_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) op_q <= op;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                // Dispatch uses the live opcode; op_q is only valid from the next state on.
                unique case (op)
                    OpLw, OpSw:    state_d = StMemAdr;
                    OpRType:       state_d = StRgExe;
                    OpBeq:         state_d = StBranch;
                    OpJ:           state_d = StJump;
                    OpOri, OpAddi: state_d = StIExe;
                    default:       state_d = StTrap;
                endcase
            end
            StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StRgExe:  state_d = StRgWb;
            StIExe:   state_d = StIWb;
            StMemWb, StRgWb, StIWb, StBranch, StJump: state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUctr      = 2'b00;
        trap        = 1'b0;
        if (rst) begin
            // Present a quiescent FETCH with no architectural writes.
            mem_req = 1'b1;
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
        end else begin
            unique case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                StDecode: ALUSrcB = 2'b11;
                StMemAdr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                StMemRd: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                StMemWr: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                StRgExe: begin
                    ALUSrcA = 1'b1;
                    ALUctr  = 2'b10;
                end
                StRgWb: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                StBranch: begin
                    ALUSrcA     = 1'b1;
                    ALUctr      = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                StJump: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                StIExe: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUctr  = (op_q == OpOri) ? 2'b11 : 2'b00;
                end
                StIWb:   RegWrite = 1'b1;
                StTrap:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule
